// File: rtl/instr_mem_bundle_if.sv
// Fetch-side bus of the instruction memory bundle: the fetch request, the
// program-load write port and the registered bundle returned to decode.
interface instr_mem_bundle_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ISSUE_WIDTH = 2
) ();

    logic                          fetch_req;
    logic [ADDR_W-1:0]             fetch_addr;
    logic                          stall;
    logic                          flush;
    logic                          prog_we;
    logic [ADDR_W-1:0]             prog_addr;
    logic [DATA_W-1:0]             prog_data;
    logic                          bundle_valid;
    logic [ADDR_W-1:0]             bundle_pc;
    logic [ISSUE_WIDTH*DATA_W-1:0] bundle_instr;
    logic [ISSUE_WIDTH-1:0]        slot_valid;
    logic                          fetch_err;

    // Fetch unit / program loader side
    modport master (
        output fetch_req, fetch_addr, stall, flush,
        output prog_we, prog_addr, prog_data,
        input  bundle_valid, bundle_pc, bundle_instr, slot_valid, fetch_err
    );

    // Instruction memory side
    modport slave (
        input  fetch_req, fetch_addr, stall, flush,
        input  prog_we, prog_addr, prog_data,
        output bundle_valid, bundle_pc, bundle_instr, slot_valid, fetch_err
    );

endinterface

// File: rtl/instr_mem_bundle.sv
// Registered instruction memory for the superscalar fetch stage. Each fetch
// returns ISSUE_WIDTH consecutive words one cycle later, with per-slot valid
// bits, misalignment/range error, stall hold, flush and a program-load port.
module instr_mem_bundle #(
    parameter int               DEPTH_WORDS = 64,
    parameter int               ISSUE_WIDTH = 2,
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 32,
    parameter logic [DATA_W-1:0] NOP_WORD   = 32'h00000000
) (
    input logic               clk,
    input logic               rst_n,
    instr_mem_bundle_if.slave bus
);

    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH_WORDS);

    // Preloaded with NOPs; reset never touches the array so loaded programs survive.
    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: NOP_WORD};

    logic [ADDR_W-1:0]             base_idx;
    logic [ADDR_W-1:0]             slot_idx;
    logic [ADDR_W-1:0]             prog_idx;
    logic                          misaligned;
    logic                          next_err;
    logic [ISSUE_WIDTH-1:0]        next_slot_valid;
    logic [ISSUE_WIDTH*DATA_W-1:0] next_instr;
    logic                          unused_prog_lsbs;

    // Word address of the load; the byte offset bits carry no meaning.
    assign prog_idx         = {2'b00, bus.prog_addr[ADDR_W-1:2]};
    assign unused_prog_lsbs = ^bus.prog_addr[1:0];

    // Program-load write; out-of-range words are dropped, stall/flush do not gate it.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (prog_idx < DEPTH_LIMIT)) begin
            mem[prog_idx[MEM_AW-1:0]] <= bus.prog_data;
        end
    end

    // Build the candidate bundle from the current array contents (old data on a same-edge write).
    always_comb begin
        next_instr      = {ISSUE_WIDTH{NOP_WORD}};
        next_slot_valid = '0;
        slot_idx        = '0;
        misaligned      = (bus.fetch_addr[1:0] != 2'b00);
        base_idx        = {2'b00, bus.fetch_addr[ADDR_W-1:2]};
        next_err        = misaligned || (base_idx >= DEPTH_LIMIT);
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            slot_idx = base_idx + ADDR_W'(k);
            if (!misaligned && (slot_idx < DEPTH_LIMIT)) begin
                next_slot_valid[k]              = 1'b1;
                next_instr[k*DATA_W +: DATA_W]  = mem[slot_idx[MEM_AW-1:0]];
            end
        end
    end

    // Output register: flush beats stall, stall beats a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bundle_valid <= 1'b0;
            bus.bundle_pc    <= '0;
            bus.bundle_instr <= {ISSUE_WIDTH{NOP_WORD}};
            bus.slot_valid   <= '0;
            bus.fetch_err    <= 1'b0;
        end else if (bus.flush) begin
            bus.bundle_valid <= 1'b0;
            bus.slot_valid   <= '0;
            bus.fetch_err    <= 1'b0;
        end else if (bus.stall) begin
            bus.bundle_valid <= bus.bundle_valid;
        end else if (bus.fetch_req) begin
            bus.bundle_valid <= 1'b1;
            bus.bundle_pc    <= bus.fetch_addr;
            bus.bundle_instr <= next_instr;
            bus.slot_valid   <= next_slot_valid;
            bus.fetch_err    <= next_err;
        end else begin
            bus.bundle_valid <= 1'b0;
            bus.slot_valid   <= '0;
            bus.fetch_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_bundle.sv
// Directed testbench for instr_mem_bundle with hand-computed expectations.
module tb_instr_mem_bundle;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IW     = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    instr_mem_bundle_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ISSUE_WIDTH(IW)) bus ();

    instr_mem_bundle #(
        .DEPTH_WORDS(64),
        .ISSUE_WIDTH(IW),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NOP_WORD(32'h00000000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic stl, input logic fls);
        bus.fetch_req  = req;
        bus.fetch_addr = addr;
        bus.stall      = stl;
        bus.flush      = fls;
    endtask

    task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        step();
        bus.prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err});
        end
        checks++;
        if ({bus.bundle_pc, bus.bundle_instr} !== 96'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus.bundle_pc, bus.bundle_instr});
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_program_load();
        prog_write(32'h0, 32'h8C010000);
        prog_write(32'h4, 32'h8C020004);
        prog_write(32'h8, 32'h00221820);
        prog_write(32'hC, 32'hACA30000);
        prog_write(32'h20, 32'h20202020);
        prog_write(32'hFC, 32'h12345678);
        // index 64 is out of range; must not alias onto word 0
        prog_write(32'h100, 32'hBAD0BAD0);
    endtask

    task automatic test_basic_fetch();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err} !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL fetch0_flags: got %b expected 1110",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err});
        end
        checks++;
        if (bus.bundle_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL fetch0_pc: got %h expected 00000000", bus.bundle_pc);
        end
        checks++;
        if (bus.bundle_instr !== 64'h8C020004_8C010000) begin
            failures++;
            $display("[TB] FAIL fetch0_instr: got %h expected 8c0200048c010000", bus.bundle_instr);
        end
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_pc, bus.bundle_instr} !== {32'h4, 64'h00221820_8C020004}) begin
            failures++;
            $display("[TB] FAIL fetch4: got %h expected 00000004002218208c020004",
                     {bus.bundle_pc, bus.bundle_instr});
        end
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_pc, bus.bundle_instr}
            !== {4'b0000, 32'h4, 64'h00221820_8C020004}) begin
            failures++;
            $display("[TB] FAIL idle_hold: got %b/%h expected 0000/00000004002218208c020004",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err},
                     {bus.bundle_pc, bus.bundle_instr});
        end
    endtask

    task automatic test_top_boundary();
        applyStimulus(1'b1, 32'hFC, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err} !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL top_flags: got %b expected 1010",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err});
        end
        checks++;
        if (bus.bundle_instr !== 64'h00000000_12345678) begin
            failures++;
            $display("[TB] FAIL top_instr: got %h expected 0000000012345678", bus.bundle_instr);
        end
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_instr} !== {4'b1001, 64'h0}) begin
            failures++;
            $display("[TB] FAIL range_err: got %b/%h expected 1001/0",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err}, bus.bundle_instr);
        end
    endtask

    task automatic test_misaligned();
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_pc, bus.bundle_instr}
            !== {4'b1001, 32'h6, 64'h0}) begin
            failures++;
            $display("[TB] FAIL misaligned: got %b/%h expected 1001/00000006_0",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err},
                     {bus.bundle_pc, bus.bundle_instr});
        end
    endtask

    task automatic test_stall();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0);
        // word 9 written while stalled; the write must still land
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'h24;
        bus.prog_data = 32'h99990009;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.prog_we = 1'b0;
            checks++;
            if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_pc, bus.bundle_instr}
                !== {4'b1110, 32'h8, 64'hACA30000_00221820}) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d]: got %b/%h expected 1110/00000008aca3000000221820", i,
                         {bus.bundle_valid, bus.slot_valid, bus.fetch_err},
                         {bus.bundle_pc, bus.bundle_instr});
            end
        end
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_pc, bus.bundle_instr}
            !== {4'b1110, 32'h20, 64'h99990009_20202020}) begin
            failures++;
            $display("[TB] FAIL stall_release: got %b/%h expected 1110/000000209999000920202020",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err},
                     {bus.bundle_pc, bus.bundle_instr});
        end
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b1);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL stall_flush: got %b expected 0000",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err});
        end
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        step();
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.bundle_pc} !== {3'b000, 32'h6}) begin
            failures++;
            $display("[TB] FAIL flush_drop: got %b/%h expected 000/00000006",
                     {bus.bundle_valid, bus.slot_valid}, bus.bundle_pc);
        end
    endtask

    task automatic test_read_before_write();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'hB;
        bus.prog_data = 32'hDEADBEEF;
        step();
        bus.prog_we = 1'b0;
        checks++;
        if (bus.bundle_instr[31:0] !== 32'h00221820) begin
            failures++;
            $display("[TB] FAIL rbw_old: got %h expected 00221820", bus.bundle_instr[31:0]);
        end
        step();
        checks++;
        if (bus.bundle_instr !== 64'hACA30000_DEADBEEF) begin
            failures++;
            $display("[TB] FAIL rbw_new: got %h expected aca30000deadbeef", bus.bundle_instr);
        end
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.bundle_instr[31:0] !== 32'h8C010000) begin
            failures++;
            $display("[TB] FAIL oor_write: got %h expected 8c010000", bus.bundle_instr[31:0]);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.bundle_valid, bus.slot_valid, bus.fetch_err, bus.bundle_pc, bus.bundle_instr}
            !== {4'b0000, 32'h0, 64'h0}) begin
            failures++;
            $display("[TB] FAIL async_reset: got %b/%h expected 0000/0",
                     {bus.bundle_valid, bus.slot_valid, bus.fetch_err},
                     {bus.bundle_pc, bus.bundle_instr});
        end
        step();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.bundle_valid, bus.bundle_instr[31:0]} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL mem_persist: got %b/%h expected 1/deadbeef",
                     bus.bundle_valid, bus.bundle_instr[31:0]);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_program_load();
        test_basic_fetch();
        test_top_boundary();
        test_misaligned();
        test_stall();
        test_flush();
        test_read_before_write();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
